// File: rtl/bus_ctrl_if.sv
// Bus controller signal bundle: CPU request side plus the per-device select/data side.
// The controller uses the slave modport, and the CPU/device environment uses the master modport.
interface bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) ();
  logic [ADDR_W-1:0]      cpu_addr;
  logic                   cpu_rd_req;
  logic                   cpu_wr_en;
  logic                   cpu_ready;
  logic [DATA_W-1:0]      cpu_rd_data;
  logic [NREG-1:0]        dev_cs;
  logic [NREG-1:0]        dev_wr_en;
  logic [NREG*DATA_W-1:0] dev_rd_data;
  logic [NREG-1:0]        dev_wait;
  logic                   bus_err;

  modport slave (
    input  cpu_addr, cpu_rd_req, cpu_wr_en, dev_rd_data, dev_wait,
    output cpu_ready, cpu_rd_data, dev_cs, dev_wr_en, bus_err
  );

  modport master (
    output cpu_addr, cpu_rd_req, cpu_wr_en, dev_rd_data, dev_wait,
    input  cpu_ready, cpu_rd_data, dev_cs, dev_wr_en, bus_err
  );
endinterface

// File: rtl/bus_ctrl.sv
// CPU bus controller: mask/match region decode, latched chip selects, gated write enables,
// and reads stretched by per-region wait states, device wait and a timeout.
module bus_ctrl #(
  parameter int                     ADDR_W       = 16,
  parameter int                     DATA_W       = 8,
  parameter int                     NREG         = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK     = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MATCH    = '0,
  parameter logic [NREG*4-1:0]      REG_WAIT     = '0,
  parameter int                     TIMEOUT      = 64,
  parameter logic [DATA_W-1:0]      DEFAULT_DATA = {DATA_W{1'b1}}
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  bus_ctrl_if.slave  bus
);

  localparam int                IDX_W     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int                TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic                r_rd_req_q;
  logic                r_cpu_ready;
  logic [DATA_W-1:0]   r_cpu_rd_data;
  logic [NREG-1:0]     r_dev_cs;
  logic                r_bus_err;
  logic [3:0]          r_cnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [IDX_W-1:0]    r_sel_idx;
  logic                r_unmapped;
  logic                r_abort;

  logic [NREG-1:0]     w_hit;
  logic [NREG-1:0]     w_sel;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_hit_any;
  logic                w_rd_rise;
  logic                w_wait_done;
  logic [3:0]          w_wait_tbl [NREG];
  logic [DATA_W-1:0]   w_dev_data [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign w_hit[gi]      = (bus.cpu_addr & REG_MASK[gi*ADDR_W +: ADDR_W])
                              == REG_MATCH[gi*ADDR_W +: ADDR_W];
      assign w_wait_tbl[gi] = REG_WAIT[gi*4 +: 4];
      assign w_dev_data[gi] = bus.dev_rd_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the top down so the lowest-index hit is the one that sticks.
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel     = '0;
        w_sel[i]  = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  assign w_hit_any   = |w_hit;
  assign w_rd_rise   = bus.cpu_rd_req & ~r_rd_req_q;
  assign w_wait_done = (r_cnt == 4'd0) && (r_unmapped || !bus.dev_wait[r_sel_idx]);

  // Writes complete in the cycle they are presented, so the enable must bypass the FSM registers.
  assign bus.dev_wr_en   = (r_state == ST_IDLE && bus.cpu_wr_en) ? w_sel : '0;
  assign bus.cpu_ready   = r_cpu_ready;
  assign bus.cpu_rd_data = r_cpu_rd_data;
  assign bus.dev_cs      = r_dev_cs;
  assign bus.bus_err     = r_bus_err;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_rd_req_q    <= 1'b0;
      r_cpu_ready   <= 1'b1;
      r_cpu_rd_data <= '0;
      r_dev_cs      <= '0;
      r_bus_err     <= 1'b0;
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_sel_idx     <= '0;
      r_unmapped    <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_rd_req_q <= bus.cpu_rd_req;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_wr_en) begin
            r_dev_cs <= w_sel;
            if (!w_hit_any) r_bus_err <= 1'b1;
          end
          if (w_rd_rise) begin
            r_dev_cs    <= w_sel;
            r_sel_idx   <= w_sel_idx;
            r_unmapped  <= !w_hit_any;
            r_abort     <= 1'b0;
            r_cnt       <= w_hit_any ? w_wait_tbl[w_sel_idx] : 4'd0;
            r_tcnt      <= '0;
            r_cpu_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          // A normal completion on the last allowed cycle is not treated as an abort.
          if (w_wait_done) begin
            r_state <= ST_DONE;
          end else if (r_tcnt == TCNT_LAST) begin
            r_state <= ST_DONE;
            r_abort <= 1'b1;
          end
          if (bus.cpu_wr_en) r_bus_err <= 1'b1;
        end
        ST_DONE: begin
          r_cpu_rd_data <= (r_unmapped || r_abort) ? DEFAULT_DATA : w_dev_data[r_sel_idx];
          r_bus_err     <= r_unmapped | r_abort | bus.cpu_wr_en;
          r_cpu_ready   <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: table of read/write vectors on a four-region map,
// plus hand-written sequences for reset mid-read, held request and simultaneous access.
module tb_bus_ctrl;

  localparam logic [63:0] MASK  = {16'hFF00, 16'hFF80, 16'h8000, 16'hC000};
  localparam logic [63:0] MATCH = {16'h9200, 16'h9000, 16'h0000, 16'hC000};
  localparam logic [15:0] WAITS = {4'd0, 4'd3, 4'd1, 4'd0};
  localparam int          NEVER = 255;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;

  bus_ctrl_if #(.ADDR_W(16), .DATA_W(8), .NREG(4)) bus ();

  bus_ctrl #(
    .ADDR_W(16), .DATA_W(8), .NREG(4),
    .REG_MASK(MASK), .REG_MATCH(MATCH), .REG_WAIT(WAITS),
    .TIMEOUT(64), .DEFAULT_DATA(8'hFF)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    int          drop;   // edges after the read starts at which dev_wait is released
    int          lat;
    logic [7:0]  data;
    logic [3:0]  cs;
    logic        err;
    logic [3:0]  wr;
  } vec_t;

  vec_t vecs[9];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_read(input vec_t v);
    int k;
    bus.cpu_addr   = v.addr;
    bus.dev_wait   = (v.drop != 0) ? 4'hF : 4'h0;
    bus.cpu_rd_req = 1'b1;
    tick();
    k = 0;
    check("rd_ready_low", bus.cpu_ready, 1'b0);
    while (bus.cpu_ready == 1'b0 && k < 200) begin
      if (k == v.drop) bus.dev_wait = 4'h0;
      tick();
      k++;
    end
    check("rd_latency", k, v.lat);
    check("rd_data", bus.cpu_rd_data, v.data);
    check("rd_err", bus.bus_err, v.err);
    check("rd_cs", bus.dev_cs, v.cs);
    $display("[TB] read  addr=%h lat=%0d data=%h cs=%b err=%b", v.addr, k, bus.cpu_rd_data,
             bus.dev_cs, bus.bus_err);
    bus.cpu_rd_req = 1'b0;
    bus.dev_wait   = 4'h0;
    tick();
    check("rd_err_pulse_end", bus.bus_err, 1'b0);
  endtask

  task automatic do_write(input vec_t v);
    bus.cpu_addr  = v.addr;
    bus.cpu_wr_en = 1'b1;
    #1;
    check("wr_en_comb", bus.dev_wr_en, v.wr);
    tick();
    bus.cpu_wr_en = 1'b0;
    #1;
    check("wr_en_one_cycle", bus.dev_wr_en, 4'h0);
    check("wr_cs", bus.dev_cs, v.cs);
    check("wr_err", bus.bus_err, v.err);
    check("wr_ready", bus.cpu_ready, 1'b1);
    $display("[TB] write addr=%h cs=%b err=%b", v.addr, bus.dev_cs, bus.bus_err);
    tick();
    check("wr_err_pulse_end", bus.bus_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   falls;
    logic prev;
    bit   idle_ok;

    //            wr    addr      drop   lat  data   cs     err   wr
    vecs[0] = '{1'b0, 16'hC123, 0,     2,  8'hA5, 4'h1, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 16'h9010, 5,     7,  8'h3C, 4'h4, 1'b0, 4'h0};
    vecs[2] = '{1'b1, 16'h9201, 0,     0,  8'h00, 4'h8, 1'b0, 4'h8};
    vecs[3] = '{1'b1, 16'hA000, 0,     0,  8'h00, 4'h0, 1'b1, 4'h0};
    vecs[4] = '{1'b0, 16'hA000, 0,     2,  8'hFF, 4'h0, 1'b1, 4'h0};
    vecs[5] = '{1'b0, 16'h0100, NEVER, 65, 8'hFF, 4'h2, 1'b1, 4'h0};
    vecs[6] = '{1'b0, 16'h0100, 0,     3,  8'h5A, 4'h2, 1'b0, 4'h0};
    vecs[7] = '{1'b0, 16'h9250, 0,     2,  8'hC3, 4'h8, 1'b0, 4'h0};
    vecs[8] = '{1'b1, 16'hC000, 0,     0,  8'h00, 4'h1, 1'b0, 4'h1};

    bus.cpu_addr    = 16'h0000;
    bus.cpu_rd_req  = 1'b0;
    bus.cpu_wr_en   = 1'b0;
    bus.dev_wait    = 4'h0;
    bus.dev_rd_data = {8'hC3, 8'h3C, 8'h5A, 8'hA5};

    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", bus.cpu_ready, 1'b1);
    check("rst_cs", bus.dev_cs, 4'h0);
    check("rst_err", bus.bus_err, 1'b0);
    check("rst_data", bus.cpu_rd_data, 8'h00);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else               do_read(vecs[i]);
    end

    // Reset pulsed five cycles into a stalled read.
    bus.cpu_addr   = 16'h0100;
    bus.dev_wait   = 4'hF;
    bus.cpu_rd_req = 1'b1;
    tick();
    check("rstmid_started", bus.cpu_ready, 1'b0);
    repeat (5) tick();
    reset_n        = 1'b0;
    bus.cpu_rd_req = 1'b0;
    bus.dev_wait   = 4'h0;
    tick();
    check("rstmid_ready", bus.cpu_ready, 1'b1);
    check("rstmid_data", bus.cpu_rd_data, 8'h00);
    check("rstmid_cs", bus.dev_cs, 4'h0);
    check("rstmid_err", bus.bus_err, 1'b0);
    reset_n = 1'b1;
    idle_ok = 1'b1;
    repeat (3) begin
      tick();
      if (bus.cpu_ready !== 1'b1) idle_ok = 1'b0;
    end
    check("rstmid_idle", idle_ok, 1'b1);
    $display("[TB] reset mid-read done");
    do_read(vecs[0]);

    // Request held high for 20 cycles, with a write attempted during WAIT.
    bus.cpu_addr   = 16'h9010;
    bus.cpu_rd_req = 1'b1;
    prev  = 1'b1;
    falls = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (prev && !bus.cpu_ready) falls++;
      prev = bus.cpu_ready;
      if (c == 0) begin
        bus.cpu_wr_en = 1'b1;
        #1;
        check("hold_wr_dropped", bus.dev_wr_en, 4'h0);
      end
      if (c == 1) begin
        check("hold_wr_err", bus.bus_err, 1'b1);
        bus.cpu_wr_en = 1'b0;
      end
    end
    check("hold_single_read", falls, 1);
    check("hold_ready", bus.cpu_ready, 1'b1);
    check("hold_data", bus.cpu_rd_data, 8'h3C);
    $display("[TB] held request reads=%0d", falls);
    bus.cpu_rd_req = 1'b0;
    tick();

    // Simultaneous write and read start in IDLE.
    bus.cpu_addr   = 16'h9201;
    bus.cpu_wr_en  = 1'b1;
    bus.cpu_rd_req = 1'b1;
    #1;
    check("sim_wr_en", bus.dev_wr_en, 4'h8);
    tick();
    bus.cpu_wr_en = 1'b0;
    check("sim_cs", bus.dev_cs, 4'h8);
    check("sim_ready_low", bus.cpu_ready, 1'b0);
    tick();
    tick();
    check("sim_ready", bus.cpu_ready, 1'b1);
    check("sim_data", bus.cpu_rd_data, 8'hC3);
    $display("[TB] simultaneous write+read data=%h", bus.cpu_rd_data);
    bus.cpu_rd_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
